obi_resp_filter: RTL

- Response-side companion of the core-side OBI request register slice. Sits between that slice's registered request and the bus.
- Counts outstanding accepted transactions and caps them at MAX_OUTSTANDING.
- On clear_pipeline, drops the responses of every transaction in flight at the flush, so the core never sees stale instruction data.
- Forwarded responses are registered: one cycle of latency to the core.

---
 rtl/obi_resp_filter.sv | 93 +++++++++
 1 files changed

// File: rtl/obi_resp_filter.sv
// ============================================================================
// obi_resp_filter : outstanding-transaction cap and flush-aware response drop
// Optional macro OBI_RESP_FILTER_ERR_EN adds sticky spurious_o flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module obi_resp_filter #(
  parameter int  MAX_OUTSTANDING = 2,
  parameter int  DATA_WIDTH      = 32,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_pipeline,
  input  logic                  req_i,
  output logic                  gnt_o,
  output logic                  bus_req_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  draining_o
`ifdef OBI_RESP_FILTER_ERR_EN
  ,
  output logic                  spurious_o
`endif
);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             full, accept, ret, fwd;
  state_t           state;

  always_comb begin
    full          = (outstanding_q == CNT_W'(MAX_OUTSTANDING));
    accept        = req_i & bus_gnt_i & ~full;
    ret           = bus_rvalid_i & (outstanding_q != '0);
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(ret);
    state         = (drop_q != '0) ? DRAIN : NORMAL;

    // A flush marks everything in flight (including this cycle's accept) stale.
    drop_d = drop_q;
    if (clear_pipeline) begin
      drop_d = outstanding_d;
    end else if (ret && (state == DRAIN)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    fwd = ret & (state == NORMAL) & ~clear_pipeline;
  end

  assign bus_req_o     = req_i & ~full;
  assign gnt_o         = bus_gnt_i & req_i & ~full;
  assign outstanding_o = outstanding_q;
  assign draining_o    = (state == DRAIN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      drop_q        <= '0;
      core_rvalid_o <= 1'b0;
      core_rdata_o  <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      core_rvalid_o <= fwd;
      if (fwd) begin
        core_rdata_o <= bus_rdata_i;
      end
    end
  end

`ifdef OBI_RESP_FILTER_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spurious_o <= 1'b0;
    end else if (bus_rvalid_i && (outstanding_q == '0)) begin
      spurious_o <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
